// File: rtl/lz77_pkg.sv
// Shared types and default widths for the LZ77 token sequencer.
package lz77_pkg;

   localparam int POS_W      = 4;
   localparam int LEN_W      = 3;
   localparam int CHAR_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;  // '$'

   // One decode token: copy (pos, len) followed by a literal character.
   typedef struct packed {
      logic [POS_W-1:0]  pos;
      logic [LEN_W-1:0]  len;
      logic [CHAR_W-1:0] ch;
   } lz77_tok_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } lz77_seq_state_e;

endpackage

// File: rtl/lz77_tok_fifo.sv
// Small synchronous token FIFO with full/empty flags and a combinational
// head. The head reads as all-zero while the FIFO is empty.
module lz77_tok_fifo
   import lz77_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  lz77_tok_t wr_tok,
   output lz77_tok_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   lz77_tok_t       mem_q [DEPTH];
   lz77_tok_t       mem_d [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Next-state for storage and pointers; overflow/underflow are ignored.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_tok;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop && !empty)
         rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // State registers; reset flushes the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/lz77_token_sequencer.sv
// Token-level controller for the LZ77 decode core: buffers tokens, enables
// the core for len+1 cycles per token, qualifies its output and stops after
// the terminating '$' literal.
// Optional: define LZ77_SEQ_STATS_EN for saturating token/char counters.
module lz77_token_sequencer
   import lz77_pkg::*;
#(
   parameter int                POS_W      = lz77_pkg::POS_W,
   parameter int                LEN_W      = lz77_pkg::LEN_W,
   parameter int                CHAR_W     = lz77_pkg::CHAR_W,
   parameter int                FIFO_DEPTH = lz77_pkg::FIFO_DEPTH,
   parameter logic [CHAR_W-1:0] END_CHAR   = lz77_pkg::END_CHAR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic [POS_W-1:0]  tok_pos,
   input  logic [LEN_W-1:0]  tok_len,
   input  logic [CHAR_W-1:0] tok_char,
   output logic              dec_en,
   output logic [POS_W-1:0]  dec_pos,
   output logic [LEN_W-1:0]  dec_len,
   output logic [CHAR_W-1:0] dec_char,
   input  logic [CHAR_W-1:0] dec_char_nxt,
   output logic              out_valid,
   output logic [CHAR_W-1:0] out_char,
   output logic              done
`ifdef LZ77_SEQ_STATS_EN
   ,
   output logic [15:0]       stat_tokens,
   output logic [15:0]       stat_chars
`endif
);

   lz77_seq_state_e   state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q, done_d;

   lz77_tok_t         wr_tok, head;
   logic              full, empty, push, pop, last;

   assign wr_tok = '{pos: tok_pos, len: tok_len, ch: tok_char};

   lz77_tok_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .pop    (pop),
      .wr_tok (wr_tok),
      .head   (head),
      .full   (full),
      .empty  (empty)
   );

   assign tok_ready = !full && (state_q == ST_IDLE || state_q == ST_RUN);
   assign push      = tok_valid && tok_ready;
   assign dec_en    = (state_q == ST_RUN) && !empty;
   // Literal cycle of the head token: it retires here and nowhere else,
   // so the FIFO cannot run dry in the middle of a copy.
   assign last      = dec_en && (cnt_q == head.len);
   assign pop       = last;

   assign dec_pos   = head.pos;
   assign dec_len   = head.len;
   assign dec_char  = head.ch;
   assign out_valid = out_valid_q;
   assign out_char  = dec_char_nxt;
   assign done      = done_q;

   // Next-state: FSM, per-token counter, output strobe, sticky done.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = dec_en;
      done_d      = done_q || (state_q == ST_DRAIN);
      case (state_q)
         ST_IDLE:  if (push) state_d = ST_RUN;
         ST_RUN:   if (last && head.ch == END_CHAR) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
      if (last)        cnt_d = '0;
      else if (dec_en) cnt_d = cnt_q + 1'b1;
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

`ifdef LZ77_SEQ_STATS_EN
   logic [15:0] stat_tokens_q, stat_tokens_d;
   logic [15:0] stat_chars_q,  stat_chars_d;

   assign stat_tokens = stat_tokens_q;
   assign stat_chars  = stat_chars_q;

   // Saturating counters of retired tokens and emitted characters.
   always_comb begin
      stat_tokens_d = stat_tokens_q;
      stat_chars_d  = stat_chars_q;
      if (pop && stat_tokens_q != 16'hFFFF)        stat_tokens_d = stat_tokens_q + 16'd1;
      if (out_valid_q && stat_chars_q != 16'hFFFF) stat_chars_d  = stat_chars_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_tokens_q <= '0;
         stat_chars_q  <= '0;
      end else begin
         stat_tokens_q <= stat_tokens_d;
         stat_chars_q  <= stat_chars_d;
      end
   end
`endif

endmodule

// File: tb/tb_lz77_token_sequencer.sv
// Directed bench for lz77_token_sequencer. A stub core registers dec_char
// on each enabled cycle; negedge monitors log enabled-cycle characters and
// qualified output characters for end-of-test comparison.
module tb_lz77_token_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       tok_valid, tok_ready;
   logic [3:0] tok_pos;
   logic [2:0] tok_len;
   logic [7:0] tok_char;
   logic       dec_en;
   logic [3:0] dec_pos;
   logic [2:0] dec_len;
   logic [7:0] dec_char;
   logic [7:0] dec_char_nxt;
   logic       out_valid;
   logic [7:0] out_char;
   logic       done;
`ifdef LZ77_SEQ_STATS_EN
   logic [15:0] stat_tokens, stat_chars;
`endif

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int w;

   logic [7:0] en_q[$];
   logic [7:0] out_q[$];
   logic [7:0] exp3 [12];

   always #5 clk = ~clk;

   lz77_token_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .tok_valid    (tok_valid),
      .tok_ready    (tok_ready),
      .tok_pos      (tok_pos),
      .tok_len      (tok_len),
      .tok_char     (tok_char),
      .dec_en       (dec_en),
      .dec_pos      (dec_pos),
      .dec_len      (dec_len),
      .dec_char     (dec_char),
      .dec_char_nxt (dec_char_nxt),
      .out_valid    (out_valid),
      .out_char     (out_char),
      .done         (done)
`ifdef LZ77_SEQ_STATS_EN
      ,
      .stat_tokens  (stat_tokens),
      .stat_chars   (stat_chars)
`endif
   );

   // Stub decoder core: registered character, advances only when enabled.
   always @(posedge clk or posedge reset) begin
      if (reset)       dec_char_nxt <= 8'h00;
      else if (dec_en) dec_char_nxt <= dec_char;
   end

   // Log enabled cycles and qualified outputs mid-cycle.
   always @(negedge clk) begin
      if (dec_en)    en_q.push_back(dec_char);
      if (out_valid) out_q.push_back(out_char);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a token at a negedge, wait (bounded) for ready, return after the accepting edge.
   task automatic push_tok(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c,
                           output int waits);
      tok_valid = 1'b1; tok_pos = p; tok_len = l; tok_char = c;
      waits = 0;
      while (!tok_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      @(negedge clk);
      tok_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tok_valid = 1'b0; tok_pos = '0; tok_len = '0; tok_char = '0;
      @(negedge clk);
      chk("rst_ready",     tok_ready, 1);
      chk("rst_dec_en",    dec_en,    0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done",      done,      0);
      chk("rst_dec_pos",   dec_pos,   0);
      chk("rst_dec_len",   dec_len,   0);
      chk("rst_dec_char",  dec_char,  0);
      reset = 1'b0;
      @(negedge clk);

      // Single literal token
      push_tok(4'd0, 3'd0, 8'h41, w);
      chk("t1_en",   dec_en,   1);
      chk("t1_char", dec_char, 8'h41);
      @(negedge clk);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_char",  out_char,  8'h41);
      chk("t1_en_off",    dec_en,    0);
      chk("t1_ready",     tok_ready, 1);
      @(negedge clk);
      chk("t1_out_valid_off", out_valid, 0);

      // Back-to-back (3,2,'B') and (1,7,'C'): 3 then 8 consecutive enables
      tok_valid = 1'b1; tok_pos = 4'd3; tok_len = 3'd2; tok_char = 8'h42;
      @(negedge clk);
      tok_pos = 4'd1; tok_len = 3'd7; tok_char = 8'h43;
      for (int i = 0; i < 11; i++) begin
         if (i == 1) tok_valid = 1'b0;
         chk($sformatf("t2_en_%0d", i),  dec_en,  1);
         chk($sformatf("t2_pos_%0d", i), dec_pos, (i < 3) ? 4'd3 : 4'd1);
         chk($sformatf("t2_len_%0d", i), dec_len, (i < 3) ? 3'd2 : 3'd7);
         @(negedge clk);
      end
      chk("t2_en_off",    dec_en,    0);
      chk("t2_out_valid", out_valid, 1);
      chk("t2_out_char",  out_char,  8'h43);
      @(negedge clk);
      en_q.delete(); out_q.delete();

      // Backpressure: 5 tokens, first len=7, depth 4
      push_tok(4'd0, 3'd7, 8'h61, w);
      push_tok(4'd1, 3'd0, 8'h62, w);
      push_tok(4'd2, 3'd0, 8'h63, w);
      push_tok(4'd3, 3'd0, 8'h64, w);
      chk("t3_ready_full", tok_ready, 0);
      push_tok(4'd4, 3'd0, 8'h65, w);
      chk("t3_wait_cycles", w, 5);
      repeat (8) @(negedge clk);
      exp3 = '{8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h61,
               8'h62, 8'h63, 8'h64, 8'h65};
      chk("t3_en_count",  en_q.size(),  12);
      chk("t3_out_count", out_q.size(), 12);
      for (int i = 0; i < 12; i++)
         if (i < en_q.size()) chk($sformatf("t3_en_char_%0d", i), en_q[i], exp3[i]);
      if (out_q.size() == 12) chk("t3_out_last", out_q[11], 8'h65);
      en_q.delete(); out_q.delete();

      // Stall: (0,1,'D'), 3 idle cycles, (0,0,'E')
      push_tok(4'd0, 3'd1, 8'h44, w);
      @(negedge clk);
      chk("t4_en_second", dec_en, 1);
      @(negedge clk);
      chk("t4_gap0", dec_en, 0);
      @(negedge clk);
      chk("t4_gap1", dec_en, 0);
      @(negedge clk);
      chk("t4_gap2", dec_en, 0);
      push_tok(4'd0, 3'd0, 8'h45, w);
      repeat (3) @(negedge clk);
      chk("t4_en_count",  en_q.size(),  3);
      chk("t4_out_count", out_q.size(), 3);
      if (en_q.size() == 3) begin
         chk("t4_en0", en_q[0], 8'h44);
         chk("t4_en1", en_q[1], 8'h44);
         chk("t4_en2", en_q[2], 8'h45);
      end
      en_q.delete(); out_q.delete();

      // Reset mid-token at cnt=2, then a fresh token decodes normally
      push_tok(4'd0, 3'd5, 8'h47, w);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5_en_off",    dec_en,    0);
      chk("t5_ready",     tok_ready, 1);
      chk("t5_head_len",  dec_len,   0);
      chk("t5_head_char", dec_char,  0);
      chk("t5_out_valid", out_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      en_q.delete(); out_q.delete();
      push_tok(4'd1, 3'd2, 8'h48, w);
      repeat (4) @(negedge clk);
      chk("t5_en_count",  en_q.size(),  3);
      chk("t5_out_count", out_q.size(), 3);
      if (out_q.size() == 3) chk("t5_out_last", out_q[2], 8'h48);
      en_q.delete(); out_q.delete();

      // End sign: (2,3,'$') then 'F' offered after the literal
      push_tok(4'd2, 3'd3, 8'h24, w);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("t6_literal_en", dec_en, 1);
      @(negedge clk);
      tok_valid = 1'b1; tok_pos = 4'd0; tok_len = 3'd0; tok_char = 8'h46;
      chk("t6_out_valid", out_valid, 1);
      chk("t6_out_char",  out_char,  8'h24);
      chk("t6_en_off",    dec_en,    0);
      chk("t6_ready_off", tok_ready, 0);
      chk("t6_done_pre",  done,      0);
      @(negedge clk);
      chk("t6_done",          done,      1);
      chk("t6_out_valid_off", out_valid, 0);
      chk("t6_ready_done",    tok_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t6_hold_en_%0d", i),   dec_en, 0);
         chk($sformatf("t6_hold_done_%0d", i), done,   1);
      end
      tok_valid = 1'b0;
      chk("t6_en_count",  en_q.size(),  4);
      chk("t6_out_count", out_q.size(), 4);
      if (out_q.size() == 4) chk("t6_out_last", out_q[3], 8'h24);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
